// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/full controller for an async FIFO: Gray write pointer, write address/enable, full/almost-full/level/overflow.
// Latency: pointer and flags are registered (1 wclk); read-pointer changes reach the flags 3 wclk edges later.
// Backpressure: writes are dropped while wfull is set (wen=0) and the attempt sets the sticky woverflow.
module wptr_full_ctrl #(
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr_async,
    input  logic             wovf_clr,
    output logic [ASIZE:0]   wptr,
    output logic [ASIZE-1:0] waddr,
    output logic             wen,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbinnext;
    logic [ASIZE:0] wgraynext;
    logic [ASIZE:0] rq1;
    logic [ASIZE:0] rq2;
    logic [ASIZE:0] rbin_s;
    logic [ASIZE:0] level_next;
    logic           full_next;

    assign wen       = winc & ~wfull;
    assign waddr     = wbin[ASIZE-1:0];
    assign wbinnext  = wbin + {{ASIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
    end

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next  = (wgraynext == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]});
    assign level_next = wbinnext - rbin_s;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            rq1          <= '0;
            rq2          <= '0;
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            rq1          <= rptr_async;
            rq2          <= rq1;
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= full_next;
            walmost_full <= (level_next >= AF_LVL);
            wlevel       <= level_next;
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ASIZE=4, AF_THRESH=12): one task per scenario, inline checks.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [4:0] rptr_async;
    logic       wovf_clr;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wen;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_checks = 0;
    int n_fail   = 0;

    wptr_full_ctrl #(.ASIZE(4), .AF_THRESH(12)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr_async   (rptr_async),
        .wovf_clr     (wovf_clr),
        .wptr         (wptr),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr_async = 5'd0;
        step();
        step();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (wptr !== 5'd0) begin n_fail++; $display("FAIL reset_wptr got %b exp 00000", wptr); end
        n_checks++; if (waddr !== 4'd0) begin n_fail++; $display("FAIL reset_waddr got %0d exp 0", waddr); end
        n_checks++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull got %b exp 0", wfull); end
        n_checks++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b exp 0", walmost_full); end
        n_checks++; if (wlevel !== 5'd0) begin n_fail++; $display("FAIL reset_wlevel got %0d exp 0", wlevel); end
        n_checks++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", woverflow); end
    endtask

    task automatic test_fill();
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_checks++; if (wlevel !== 5'(i)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, wlevel, i); end
            n_checks++; if (walmost_full !== (i >= 12)) begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, walmost_full, (i >= 12)); end
            n_checks++; if (wfull !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, wfull, (i == 16)); end
            n_checks++; if (wptr !== gray(5'(i))) begin n_fail++; $display("FAIL fill_wptr[%0d] got %b exp %b", i, wptr, gray(5'(i))); end
        end
        n_checks++; if (wptr !== 5'b11000) begin n_fail++; $display("FAIL fill_wptr_final got %b exp 11000", wptr); end
        n_checks++; if (waddr !== 4'd0) begin n_fail++; $display("FAIL fill_waddr_final got %0d exp 0", waddr); end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (wptr !== 5'b11000) begin n_fail++; $display("FAIL ovf_wptr_hold[%0d] got %b exp 11000", i, wptr); end
            n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL ovf_wen[%0d] got %b exp 0", i, wen); end
            n_checks++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set[%0d] got %b exp 1", i, woverflow); end
        end
        winc = 1'b0; wovf_clr = 1'b1;
        step();
        n_checks++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", woverflow); end
        winc = 1'b1; wovf_clr = 1'b1;
        step();
        n_checks++; if (woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", woverflow); end
        n_checks++; if (wlevel !== 5'd16) begin n_fail++; $display("FAIL ovf_level_hold got %0d exp 16", wlevel); end
        winc = 1'b0; wovf_clr = 1'b1;
        step();
        wovf_clr = 1'b0;
    endtask

    task automatic test_read_release();
        rptr_async = 5'b00110;
        step();
        step();
        n_checks++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL rel_full_edge2 got %b exp 1", wfull); end
        n_checks++; if (wlevel !== 5'd16) begin n_fail++; $display("FAIL rel_level_edge2 got %0d exp 16", wlevel); end
        step();
        n_checks++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL rel_full_edge3 got %b exp 0", wfull); end
        n_checks++; if (wlevel !== 5'd12) begin n_fail++; $display("FAIL rel_level_edge3 got %0d exp 12", wlevel); end
        n_checks++; if (walmost_full !== 1'b1) begin n_fail++; $display("FAIL rel_af_edge3 got %b exp 1", walmost_full); end
    endtask

    // Reader trails the writer by 8; the two-flop sync plus flag register add 3 more to the observed level.
    task automatic test_stream();
        logic [4:0] wb, q1, q2, old_q2, exp_lvl, prev_ptr, diff;
        bit         wrap_seen;
        do_reset();
        winc = 1'b1;
        repeat (8) step();
        wb = 5'd8; q1 = 5'd0; q2 = 5'd0; wrap_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rptr_async = gray(wb - 5'd8);
            old_q2   = q2;
            prev_ptr = wptr;
            step();
            wb      = wb + 5'd1;
            q2      = q1;
            q1      = rptr_async;
            exp_lvl = wb - g2b(old_q2);
            diff    = wptr ^ prev_ptr;
            if (waddr == 4'd0 && prev_ptr == gray(5'd15) || waddr == 4'd0 && prev_ptr == gray(5'd31)) wrap_seen = 1'b1;
            n_checks++; if (wptr !== gray(wb)) begin n_fail++; $display("FAIL stream_wptr[%0d] got %b exp %b", i, wptr, gray(wb)); end
            n_checks++; if ($countones(diff) != 1) begin n_fail++; $display("FAIL stream_onebit[%0d] got %0d bits exp 1", i, $countones(diff)); end
            n_checks++; if (waddr !== wb[3:0]) begin n_fail++; $display("FAIL stream_waddr[%0d] got %0d exp %0d", i, waddr, wb[3:0]); end
            n_checks++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL stream_full[%0d] got %b exp 0", i, wfull); end
            n_checks++; if (wlevel !== exp_lvl) begin n_fail++; $display("FAIL stream_level[%0d] got %0d exp %0d", i, wlevel, exp_lvl); end
        end
        winc = 1'b0;
        n_checks++; if (!wrap_seen) begin n_fail++; $display("FAIL stream_wrap got 0 exp 1"); end
    endtask

    task automatic test_almost_full();
        do_reset();
        winc = 1'b1;
        repeat (11) step();
        winc = 1'b0;
        n_checks++; if (wlevel !== 5'd11) begin n_fail++; $display("FAIL af_level11 got %0d exp 11", wlevel); end
        n_checks++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL af_at11 got %b exp 0", walmost_full); end
        winc = 1'b1;
        step();
        winc = 1'b0;
        n_checks++; if (wlevel !== 5'd12) begin n_fail++; $display("FAIL af_level12 got %0d exp 12", wlevel); end
        n_checks++; if (walmost_full !== 1'b1) begin n_fail++; $display("FAIL af_at12 got %b exp 1", walmost_full); end
        rptr_async = 5'b00001;
        step();
        step();
        n_checks++; if (walmost_full !== 1'b1) begin n_fail++; $display("FAIL af_hold_edge2 got %b exp 1", walmost_full); end
        step();
        n_checks++; if (wlevel !== 5'd11) begin n_fail++; $display("FAIL af_readback_level got %0d exp 11", wlevel); end
        n_checks++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL af_readback got %b exp 0", walmost_full); end
    endtask

    task automatic test_reset_midfill();
        do_reset();
        winc = 1'b1;
        repeat (7) step();
        winc = 1'b0;
        n_checks++; if (wlevel !== 5'd7) begin n_fail++; $display("FAIL mid_level7 got %0d exp 7", wlevel); end
        #2 wrst = 1'b1;
        #1;
        n_checks++; if (wptr !== 5'd0) begin n_fail++; $display("FAIL mid_wptr got %b exp 00000", wptr); end
        n_checks++; if (waddr !== 4'd0) begin n_fail++; $display("FAIL mid_waddr got %0d exp 0", waddr); end
        n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL mid_wen got %b exp 0", wen); end
        n_checks++; if (wlevel !== 5'd0) begin n_fail++; $display("FAIL mid_wlevel got %0d exp 0", wlevel); end
        n_checks++; if ({wfull, walmost_full, woverflow} !== 3'b000) begin n_fail++; $display("FAIL mid_flags got %b exp 000", {wfull, walmost_full, woverflow}); end
        step();
        wrst = 1'b0;
        winc = 1'b1;
        step();
        winc = 1'b0;
        n_checks++; if (wptr !== 5'b00001) begin n_fail++; $display("FAIL mid_post_wptr got %b exp 00001", wptr); end
        n_checks++; if (wlevel !== 5'd1) begin n_fail++; $display("FAIL mid_post_level got %0d exp 1", wlevel); end
        n_checks++; if (waddr !== 4'd1) begin n_fail++; $display("FAIL mid_post_waddr got %0d exp 1", waddr); end
    endtask

    initial begin
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr_async = 5'd0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_stream();
        test_almost_full();
        test_reset_midfill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
